// File: rtl/color_scan_sequencer_pkg.sv
// Shared colour, filter and FSM encodings for the row-scan sequencer.
// The state encoding is reused by the RAM controller and the LED preview mux.
package color_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_GREEN  = 2'd1,
        COL_BLUE   = 2'd2,
        COL_YELLOW = 2'd3
    } color_e;

    // Sensor S2/S3 pin codes
    localparam logic [1:0] F_RED   = 2'b00;
    localparam logic [1:0] F_GREEN = 2'b11;
    localparam logic [1:0] F_BLUE  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_DECIDE,
        S_EMIT,
        S_DONE
    } state_e;

    function automatic logic [1:0] filter_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return F_RED;
            2'd1:    return F_GREEN;
            default: return F_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/color_scan_sequencer_if.sv
// Colour hand-off channel from the sequencer (master) to the RAM controller (slave).
interface color_scan_sequencer_if;
    import color_scan_sequencer_pkg::*;

    color_e color;
    logic   color_valid;
    logic   color_ready;

    modport master (output color, output color_valid, input color_ready);
    modport slave  (input color, input color_valid, output color_ready);
endinterface

// File: rtl/color_scan_sequencer_freq_gate_counter.sv
// Synchronises the sensor square wave, detects rising edges and counts them
// into a saturating counter while enabled; clear has priority over counting.
module freq_gate_counter #(
    parameter int unsigned COUNT_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               freq_in,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [COUNT_W-1:0] count_o
);

    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    logic [COUNT_W-1:0] count_q;
    logic               pulse;

    assign pulse   = sync2_q & ~prev_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= freq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (clr_i) begin
                count_q <= '0;
            end else if (en_i && pulse && (count_q != '1)) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/color_scan_sequencer.sv
// Row-scan sequencer: walks the sensor bar, measures R/G/B edge counts per sensor,
// classifies each sensor's colour and hands the codes in order to the RAM controller.
module color_scan_sequencer
    import color_scan_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SENSORS   = 4,
    parameter int unsigned SETTLE_CYCLES = 100,
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned COUNT_W       = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   freq_in,
    output logic [NUM_SENSORS-1:0] sensor_select,
    output logic [1:0]             filter_select,
    color_scan_sequencer_if.master color_bus,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned SW   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] LAST_S      = SW'(NUM_SENSORS - 1);

    state_e                 state_q;
    logic [TW-1:0]          timer_q;
    logic [SW-1:0]          s_q;
    logic [1:0]             f_q;
    logic [NUM_SENSORS-1:0] sensor_select_q;
    logic [1:0]             filter_select_q;
    color_e                 color_q;
    logic                   color_valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic [COUNT_W-1:0]     cnt_r_q;
    logic [COUNT_W-1:0]     cnt_g_q;
    logic [COUNT_W-1:0]     count;

    function automatic color_e classify(input logic [COUNT_W-1:0] r,
                                        input logic [COUNT_W-1:0] g,
                                        input logic [COUNT_W-1:0] b);
        logic [COUNT_W-1:0] hi;
        logic [COUNT_W-1:0] diff;
        hi   = (r > g) ? r : g;
        diff = (r > g) ? (r - g) : (g - r);
        if ((r > b) && (g > b) && (diff <= (hi >> 2))) return COL_YELLOW;
        if ((r >= g) && (r >= b)) return COL_RED;
        if (g >= b) return COL_GREEN;
        return COL_BLUE;
    endfunction

    freq_gate_counter #(.COUNT_W(COUNT_W)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .freq_in (freq_in),
        .clr_i   (state_q == S_SETTLE),
        .en_i    (state_q == S_GATE),
        .count_o (count)
    );

    // The counter is only cleared at the end of the first SETTLE cycle, so the
    // previous filter's result is still on count then; blue is read in DECIDE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            s_q             <= '0;
            f_q             <= 2'd0;
            sensor_select_q <= '0;
            filter_select_q <= F_RED;
            color_q         <= COL_RED;
            color_valid_q   <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            cnt_r_q         <= '0;
            cnt_g_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q         <= S_SETTLE;
                        timer_q         <= '0;
                        s_q             <= '0;
                        f_q             <= 2'd0;
                        sensor_select_q <= NUM_SENSORS'(1);
                        filter_select_q <= F_RED;
                        busy_q          <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if ((timer_q == '0) && (f_q == 2'd1)) cnt_r_q <= count;
                    if ((timer_q == '0) && (f_q == 2'd2)) cnt_g_q <= count;
                    if (timer_q == SETTLE_LAST) begin
                        timer_q <= '0;
                        state_q <= S_GATE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_GATE: begin
                    if (timer_q == GATE_LAST) begin
                        timer_q <= '0;
                        if (f_q == 2'd2) begin
                            state_q <= S_DECIDE;
                        end else begin
                            f_q             <= f_q + 2'd1;
                            filter_select_q <= filter_code(f_q + 2'd1);
                            state_q         <= S_SETTLE;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DECIDE: begin
                    color_q       <= classify(cnt_r_q, cnt_g_q, count);
                    color_valid_q <= 1'b1;
                    state_q       <= S_EMIT;
                end
                S_EMIT: begin
                    if (color_bus.color_ready) begin
                        color_valid_q <= 1'b0;
                        if (s_q == LAST_S) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            s_q             <= s_q + SW'(1);
                            f_q             <= 2'd0;
                            sensor_select_q <= sensor_select_q << 1;
                            filter_select_q <= F_RED;
                            state_q         <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    done_q          <= 1'b0;
                    busy_q          <= 1'b0;
                    sensor_select_q <= '0;
                    filter_select_q <= F_RED;
                    state_q         <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sensor_select         = sensor_select_q;
    assign filter_select         = filter_select_q;
    assign color_bus.color       = color_q;
    assign color_bus.color_valid = color_valid_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule
